// File: rtl/mc_control_fsm.sv
// Multi-cycle main control unit: Moore FSM sequencing fetch/decode/execute and driving datapath strobes.
// Optional addi support is enabled with `define MC_CONTROL_ADDI_EN.
//
// state | meaning
// ------+--------------------------------------------------
//   12  | IDLE    - post-reset, no strobes
//    0  | FETCH   - read instruction, PC+4 (waits on mem_ready)
//    1  | DECODE  - register read, branch target compute
//    2  | MEMADR  - effective address for lw/sw
//    3  | MEMRD   - data memory read (waits on mem_ready)
//    4  | MEMWB   - write MDR to rt
//    5  | MEMWR   - data memory write (waits on mem_ready)
//    6  | EXEC    - R-type ALU operation
//    7  | ALUWB   - write ALUOut to rd
//    8  | BRANCH  - beq compare and conditional PC load
//    9  | JUMP    - PC load from jump target
//   10  | ADDIEX  - addi ALU operation (feature build only)
//   11  | ADDIWB  - write ALUOut to rt (feature build only)
module mc_control_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd12
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       irwrite,
   output logic [1:0] pcsource,
   output logic       aluop1,
   output logic       aluop0,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       regwrite,
   output logic       regdst,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_IDLE   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_illegal;
   logic   w_op_legal;
   logic   w_illegal_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= state_t'(RESET_STATE);
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_illegal <= r_illegal | w_illegal_set;
      end
   end

   always_comb begin
      w_op_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: w_op_legal = 1'b1;
`ifdef MC_CONTROL_ADDI_EN
         OP_ADDI: w_op_legal = 1'b1;
`endif
         default: w_op_legal = 1'b0;
      endcase
   end

   assign w_illegal_set = (r_state == S_DECODE) && !w_op_legal;

   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:   w_state_nxt = S_FETCH;
         S_FETCH:  w_state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_state_nxt = S_MEMADR;
               OP_RTYPE:     w_state_nxt = S_EXEC;
               OP_BEQ:       w_state_nxt = S_BRANCH;
               OP_J:         w_state_nxt = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
               OP_ADDI:      w_state_nxt = S_ADDIEX;
`endif
               default:      w_state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      w_state_nxt = S_MEMRD;
            else if (op == OP_SW) w_state_nxt = S_MEMWR;
            else                  w_state_nxt = S_FETCH;
         end
         S_MEMRD:  w_state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_state_nxt = S_FETCH;
         S_MEMWR:  w_state_nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_state_nxt = S_ALUWB;
         S_ALUWB:  w_state_nxt = S_FETCH;
         S_BRANCH: w_state_nxt = S_FETCH;
         S_JUMP:   w_state_nxt = S_FETCH;
`ifdef MC_CONTROL_ADDI_EN
         S_ADDIEX: w_state_nxt = S_ADDIWB;
         S_ADDIWB: w_state_nxt = S_FETCH;
`endif
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      memtoreg    = 1'b0;
      irwrite     = 1'b0;
      pcsource    = 2'b00;
      aluop1      = 1'b0;
      aluop0      = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      case (r_state)
         S_FETCH: begin
            // IR/PC loads wait for the read to land so the PC advances only once
            memread = 1'b1;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            alusrcb = 2'b01;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop1  = 1'b1;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca     = 1'b1;
            aluop0      = 1'b1;
            pcwritecond = 1'b1;
            pcsource    = 2'b01;
         end
         S_JUMP: begin
            pcwrite  = 1'b1;
            pcsource = 2'b10;
         end
`ifdef MC_CONTROL_ADDI_EN
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
`endif
         default: ;
      endcase
   end

   assign illegal_op = r_illegal;
   assign state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed and randomized instruction streams
// compared against per-instruction expected state/strobe sequences.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
   logic [1:0] pcsource;
   logic       aluop1, aluop0, alusrca;
   logic [1:0] alusrcb;
   logic       regwrite, regdst, illegal_op;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;
   logic exp_ill = 1'b0;

   typedef struct packed {
      logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
      logic [1:0] pcsource;
      logic       aluop1, aluop0, alusrca;
      logic [1:0] alusrcb;
      logic       regwrite, regdst;
   } ctl_t;

   ctl_t obs;
   assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                 pcsource, aluop1, aluop0, alusrca, alusrcb, regwrite, regdst};

   mc_control_fsm dut (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
      .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .pcsource(pcsource),
      .aluop1(aluop1), .aluop0(aluop0), .alusrca(alusrca), .alusrcb(alusrcb),
      .regwrite(regwrite), .regdst(regdst), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

`ifdef MC_CONTROL_ADDI_EN
   localparam bit ADDI_ON = 1'b1;
`else
   localparam bit ADDI_ON = 1'b0;
`endif

   function automatic bit is_legal(input logic [5:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == JMP) ||
             (ADDI_ON && o == ADDI);
   endfunction

   // Strobe table straight from the control description; FETCH loads gated by mem_ready.
   function automatic ctl_t exp_ctl(input logic [3:0] s, input logic mr);
      ctl_t c;
      c = '0;
      case (s)
         4'd0: begin c.memread = 1; c.irwrite = mr; c.pcwrite = mr; c.alusrcb = 2'b01; end
         4'd1: c.alusrcb = 2'b11;
         4'd2: begin c.alusrca = 1; c.alusrcb = 2'b10; end
         4'd3: begin c.memread = 1; c.iord = 1; end
         4'd4: begin c.regwrite = 1; c.memtoreg = 1; end
         4'd5: begin c.memwrite = 1; c.iord = 1; end
         4'd6: begin c.alusrca = 1; c.aluop1 = 1; end
         4'd7: begin c.regwrite = 1; c.regdst = 1; end
         4'd8: begin c.alusrca = 1; c.aluop0 = 1; c.pcwritecond = 1; c.pcsource = 2'b01; end
         4'd9: begin c.pcwrite = 1; c.pcsource = 2'b10; end
         4'd10: if (ADDI_ON) begin c.alusrca = 1; c.alusrcb = 2'b10; end
         4'd11: if (ADDI_ON) c.regwrite = 1;
         default: ;
      endcase
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, o, e, $time);
      end
   endtask

   task automatic check_all(input logic [3:0] es, input logic mr);
      chk("state", 32'(state), 32'(es));
      chk("strobes", 32'(obs), 32'(exp_ctl(es, mr)));
      chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
   endtask

   // One clock cycle: drive inputs at the falling edge, check just after.
   task automatic step(input logic [3:0] es, input logic mr, input logic [5:0] o);
      @(negedge clk);
      mem_ready = mr;
      op        = o;
      #1;
      check_all(es, mr);
   endtask

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   task automatic run_instr(input logic [5:0] o, input int fst, input int mst);
      for (int i = 0; i < fst; i++) step(4'd0, 1'b0, rop());
      step(4'd0, 1'b1, rop());
      step(4'd1, 1'($urandom), o);
      if (!is_legal(o)) begin
         exp_ill = 1'b1;
      end else if (o == LW || o == SW) begin
         step(4'd2, 1'($urandom), o);
         for (int i = 0; i < mst; i++) step((o == LW) ? 4'd3 : 4'd5, 1'b0, rop());
         step((o == LW) ? 4'd3 : 4'd5, 1'b1, rop());
         if (o == LW) step(4'd4, 1'($urandom), rop());
      end else if (o == RT) begin
         step(4'd6, 1'($urandom), rop());
         step(4'd7, 1'($urandom), rop());
      end else if (o == BEQ) begin
         step(4'd8, 1'($urandom), rop());
      end else if (o == JMP) begin
         step(4'd9, 1'($urandom), rop());
      end else begin
         step(4'd10, 1'($urandom), rop());
         step(4'd11, 1'($urandom), rop());
      end
   endtask

   initial begin
      logic [5:0] o;
      reset_n   = 1'b0;
      op        = 6'b0;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_all(4'd12, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_all(4'd12, 1'b1);

      run_instr(LW, 0, 0);
      run_instr(RT, 0, 0);
      run_instr(BEQ, 0, 0);
      run_instr(JMP, 0, 0);
      run_instr(SW, 3, 3);
      run_instr(ADDI, 0, 0);
      run_instr(6'b111111, 0, 0);
      run_instr(LW, 1, 2);

      // Abort mid-MEMRD with the sticky flag already set.
      step(4'd0, 1'b1, rop());
      step(4'd1, 1'b1, LW);
      step(4'd2, 1'b1, LW);
      step(4'd3, 1'b0, rop());
      reset_n = 1'b0;
      exp_ill = 1'b0;
      #1;
      check_all(4'd12, 1'b0);
      @(negedge clk);
      #1;
      check_all(4'd12, 1'b0);
      reset_n = 1'b1;
      #1;
      check_all(4'd12, 1'b0);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 7))
            0, 7: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = BEQ;
            4: o = JMP;
            5: o = ADDI;
            default: begin
               o = rop();
               if (is_legal(o)) o = 6'b110011;
            end
         endcase
         run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      step(4'd0, 1'b0, rop());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main control unit; sits directly upstream of the ALU control decoder and drives its aluop1/aluop0 inputs.
- Also drives all datapath control strobes: PC, memory, IR, register file and mux selects.
- Decodes the 6-bit opcode from the instruction register and sequences each instruction through a Moore FSM.
- Stalls on a memory-ready handshake.

Parameters:
- RESET_STATE, 4'd12, encoding of the IDLE state entered on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- op  input  6  opcode field, IR[31:26].
- mem_ready  input  1  memory access completes this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load qualified by ALU zero.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- memtoreg  output  1  register write-data select: 1=MDR.
- irwrite  output  1  instruction register load.
- pcsource  output  2  00=ALU, 01=ALUOut, 10=jump target.
- aluop1  output  1  to ALU control decoder.
- aluop0  output  1  to ALU control decoder.
- alusrca  output  1  0=PC, 1=rs.
- alusrcb  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2.
- regwrite  output  1  register file write.
- regdst  output  1  1=rd, 0=rt.
- illegal_op  output  1  sticky unsupported-opcode flag.
- state  output  4  current state, for debug.

Behaviour:
- State register: async clear on reset_n=0 to IDLE (4'd12).
- illegal_op: async clear on reset_n=0 to 0.
- Outputs are pure Moore decode of state. Every strobe not listed for a state is 0.
- Reset values: all outputs 0, state=12.
- Reset asserted mid-instruction aborts immediately. No partial strobe survives.
- IDLE(12): no strobes. Next state FETCH unconditionally.
- FETCH(0):
  - Strobes: memread=1, irwrite=1, alusrcb=01, aluop=00, pcwrite=1, pcsource=00.
  - mem_ready=0: hold FETCH. irwrite and pcwrite are gated low while mem_ready=0, so the PC advances exactly once.
  - mem_ready=1: go to DECODE.
- DECODE(1): alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - Any other op -> FETCH, and illegal_op is set to 1 (sticky until reset).
- MEMADR(2): alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): memread=1, iord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB(4): regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR(5): memwrite=1, iord=1. Hold until mem_ready=1, then FETCH. The write is complete on the exit cycle.
- EXEC(6): alusrca=1, alusrcb=00, aluop=10. Next ALUWB.
- ALUWB(7): regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCH(8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Next FETCH.
- JUMP(9): pcwrite=1, pcsource=10. Next FETCH.
- Unused encodings (10, 11 when the optional feature is absent; 13-15): outputs 0, next IDLE.
- Op is sampled only in DECODE and MEMADR. Its value in other states is don't-care.
- Cycle counts with mem_ready tied to 1:
  - lw 5, sw 4, R-type 4, beq 3, j 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Optional Feature:
- Macro: MC_CONTROL_ADDI_EN.
- Defined:
  - op 001000 (addi) in DECODE -> ADDIEX(10): alusrca=1, alusrcb=10, aluop=00.
  - Then ADDIWB(11): regwrite=1, regdst=0, memtoreg=0. Then FETCH.
  - addi takes 4 cycles.
- Undefined: addi is treated as illegal (sets illegal_op, returns to FETCH). States 10 and 11 are unreachable and decode as unused.

Test Plan:
- Reset then release, mem_ready=1 -> state 12 then 0. All outputs 0 during reset. FETCH shows memread=1, irwrite=1, pcwrite=1.
- lw (100011), mem_ready=1 -> states 0,1,2,3,4 over 5 cycles. MEMWB has regwrite=1, memtoreg=1, regdst=0.
- R-type (000000) -> EXEC shows aluop1=1, aluop0=0. ALUWB shows regwrite=1, regdst=1. Back to FETCH after 4 cycles.
- beq (000100) -> BRANCH shows aluop1=0, aluop0=1, pcwritecond=1, pcsource=01. j shows pcwrite=1, pcsource=10.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite held high 4 cycles, exit to FETCH. Same stall in FETCH keeps pcwrite=0 until mem_ready=1.
- op 111111 -> DECODE returns to FETCH and illegal_op=1 persists. Assert reset_n=0 mid-MEMRD -> illegal_op=0, state=12 immediately.
